// File: rtl/rd73_bist_driver_pkg.sv
// rd73_bist_pkg: shared types and constants for the rd73 BIST driver.
//   state_t          - controller states
//   MODE_*           - vector generator selection (sampled on start)
//   MISR_POLY_DEFAULT- lower feedback terms of x^16+x^12+x^3+x+1
//   LFSR_TAPS/SEED   - 7-bit Fibonacci LFSR x^7+x^6+1, seeded non-zero
//   FULL_*           - vector counts used when num_vec is 0
package rd73_bist_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_t;

    localparam logic MODE_COUNT = 1'b0;
    localparam logic MODE_LFSR  = 1'b1;

    localparam logic [15:0] MISR_POLY_DEFAULT = 16'h100B;

    localparam logic [6:0] LFSR_TAPS = 7'h60;
    localparam logic [6:0] LFSR_SEED = 7'h01;
    localparam logic [6:0] CNT_SEED  = 7'h00;

    localparam logic [7:0] FULL_COUNT = 8'd128;
    localparam logic [7:0] FULL_LFSR  = 8'd127;

endpackage

// File: rtl/rd73_bist_driver_if.sv
// rd73_bist_driver_if: run control, vector/response and result signals
// between a run controller (master) and the BIST driver (slave).
//   start/mode/num_vec : run request and its configuration
//   x/x_valid          : vector driven to the downstream rd73 block
//   z0                 : response from the downstream block
//   busy/done/pass     : run status
//   signature          : MISR contents
//   ones_count         : number of captured z0 == 1
interface rd73_bist_driver_if #(
    parameter int unsigned N_IN  = 7,
    parameter int unsigned SIG_W = 16
);

    logic             start;
    logic             mode;
    logic [7:0]       num_vec;
    logic [N_IN-1:0]  x;
    logic             x_valid;
    logic             z0;
    logic             busy;
    logic             done;
    logic             pass;
    logic [SIG_W-1:0] signature;
    logic [7:0]       ones_count;

    modport master (
        output start, mode, num_vec, z0,
        input  x, x_valid, busy, done, pass, signature, ones_count
    );

    modport slave (
        input  start, mode, num_vec, z0,
        output x, x_valid, busy, done, pass, signature, ones_count
    );

endinterface

// File: rtl/rd73_bist_driver_misr.sv
// rd73_misr: serial-input multiple-input signature register.
//   clk, rst : clock, asynchronous active-high reset
//   clr      : synchronous clear (wins over en)
//   en       : shift in din this cycle
//   din      : captured response bit
//   sig      : current signature
module rd73_misr #(
    parameter int unsigned       SIG_W     = 16,
    parameter logic [SIG_W-1:0] MISR_POLY = 16'h100B
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic             din,
    output logic [SIG_W-1:0] sig
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sig <= '0;
        end else if (clr) begin
            sig <= '0;
        end else if (en) begin
            sig <= {sig[SIG_W-2:0], 1'b0}
                 ^ (sig[SIG_W-1] ? MISR_POLY : '0)
                 ^ SIG_W'(din);
        end
    end

endmodule

// File: rtl/rd73_bist_driver.sv
// rd73_bist_driver: stimulus/response stage ahead of the rd73f2 parity block.
// Issues N vectors (counter or LFSR), captures z0 DUT_LAT cycles after each
// vector, folds the responses into a MISR and counts ones, then reports
// pass = (signature == GOLDEN_SIG).
//   clk, rst : clock, asynchronous active-high reset
//   bus      : rd73_bist_driver_if slave (start/mode/num_vec in, x/x_valid
//              out, z0 in, busy/done/pass/signature/ones_count out)
module rd73_bist_driver
    import rd73_bist_pkg::*;
#(
    parameter int unsigned       N_IN       = 7,
    parameter int unsigned       DUT_LAT    = 1,
    parameter int unsigned       SIG_W      = 16,
    parameter logic [SIG_W-1:0] MISR_POLY  = SIG_W'(MISR_POLY_DEFAULT),
    parameter logic [SIG_W-1:0] GOLDEN_SIG = '0
) (
    input  logic clk,
    input  logic rst,
    rd73_bist_driver_if.slave bus
);

    localparam logic [2:0] DRAIN_LAST = 3'((DUT_LAT == 0) ? 0 : DUT_LAT - 1);

    state_t           state, state_nxt;
    logic             start_acc;
    logic             last_issue;
    logic             x_valid;
    logic             cap;
    logic             mode_q;
    logic [7:0]       n_q;
    logic [7:0]       issued;
    logic [7:0]       ones_q;
    logic [2:0]       drain_cnt;
    logic [N_IN-1:0]  x_q;
    logic [N_IN-1:0]  gen_nxt;
    logic             pass_q;
    logic [SIG_W-1:0] sig;
    logic [SIG_W-1:0] sig_nxt;

    assign start_acc  = bus.start && (state == IDLE || state == DONE);
    assign last_issue = (state == RUN) && ((issued + 8'd1) == n_q);
    assign x_valid    = (state == RUN);

    // x_q is the generator itself: it is only advanced when another vector
    // follows, so it naturally holds the last vector through DRAIN/DONE.
    always_comb begin
        gen_nxt = x_q + 1'b1;
        if (mode_q == MODE_LFSR) begin
            gen_nxt = {x_q[N_IN-2:0], ^(x_q & LFSR_TAPS)};
        end
    end

    // Capture strobe: x_valid delayed by DUT_LAT cycles.
    if (DUT_LAT == 0) begin : g_nolat
        assign cap = x_valid;
    end else begin : g_lat
        logic [DUT_LAT-1:0] vline;
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                vline <= '0;
            end else begin
                vline <= DUT_LAT'({vline, x_valid});
            end
        end
        assign cap = vline[DUT_LAT-1];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE, DONE: if (bus.start) state_nxt = RUN;
            RUN:        if (last_issue) state_nxt = (DUT_LAT > 0) ? DRAIN : DONE;
            DRAIN:      if (drain_cnt == DRAIN_LAST) state_nxt = DONE;
            default:    state_nxt = IDLE;
        endcase
    end

    // The last capture lands on the same edge that enters DONE, so pass is
    // judged against the post-update signature.
    always_comb begin
        sig_nxt = sig;
        if (cap) begin
            sig_nxt = {sig[SIG_W-2:0], 1'b0}
                    ^ (sig[SIG_W-1] ? MISR_POLY : '0)
                    ^ SIG_W'(bus.z0);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q    <= MODE_COUNT;
            n_q       <= '0;
            issued    <= '0;
            x_q       <= '0;
            ones_q    <= '0;
            drain_cnt <= '0;
            pass_q    <= 1'b0;
        end else begin
            if (start_acc) begin
                mode_q    <= bus.mode;
                n_q       <= (bus.num_vec != 8'd0) ? bus.num_vec
                           : ((bus.mode == MODE_LFSR) ? FULL_LFSR : FULL_COUNT);
                issued    <= '0;
                x_q       <= (bus.mode == MODE_LFSR) ? LFSR_SEED : CNT_SEED;
                ones_q    <= '0;
                drain_cnt <= '0;
                pass_q    <= 1'b0;
            end else begin
                if (state == RUN) begin
                    issued <= issued + 8'd1;
                    if (!last_issue) begin
                        x_q <= gen_nxt;
                    end
                end
                if (state == DRAIN) begin
                    drain_cnt <= drain_cnt + 3'd1;
                end
                if (cap && bus.z0 && (ones_q != 8'hFF)) begin
                    ones_q <= ones_q + 8'd1;
                end
                if (state != DONE && state_nxt == DONE) begin
                    pass_q <= (sig_nxt == GOLDEN_SIG);
                end
            end
        end
    end

    rd73_misr #(
        .SIG_W     (SIG_W),
        .MISR_POLY (MISR_POLY)
    ) u_misr (
        .clk (clk),
        .rst (rst),
        .clr (start_acc),
        .en  (cap),
        .din (bus.z0),
        .sig (sig)
    );

    assign bus.x          = x_q;
    assign bus.x_valid    = x_valid;
    assign bus.busy       = (state == RUN) || (state == DRAIN);
    assign bus.done       = (state == DONE);
    assign bus.pass       = pass_q;
    assign bus.signature  = sig;
    assign bus.ones_count = ones_q;

endmodule

// File: tb/tb_rd73_bist_driver.sv
// tb_rd73_bist_driver: drives two driver instances (DUT_LAT = 1 and 3) with
// a linear-response model of the rd73 block attached, and checks vectors,
// signature, ones count, pass and timing against a reference model.
module tb_rd73_bist_driver;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       mode = 1'b0;
    logic [7:0] num_vec = 8'd0;
    logic       sel = 1'b0;
    logic [6:0] key = 7'h7F;
    logic       stuck0 = 1'b0;
    logic       force1 = 1'b0;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    rd73_bist_driver_if b1 ();
    rd73_bist_driver_if b3 ();

    assign b1.start   = start & ~sel;
    assign b1.mode    = mode;
    assign b1.num_vec = num_vec;
    assign b3.start   = start & sel;
    assign b3.mode    = mode;
    assign b3.num_vec = num_vec;

    rd73_bist_driver #(.DUT_LAT(1), .GOLDEN_SIG(16'h0003)) dut1 (
        .clk (clk), .rst (rst), .bus (b1)
    );
    rd73_bist_driver #(.DUT_LAT(3), .GOLDEN_SIG(16'h000D)) dut3 (
        .clk (clk), .rst (rst), .bus (b3)
    );

    // Downstream block: z0 = parity of (x & key), with fault overrides.
    function automatic logic resp(input logic [6:0] v);
        if (stuck0) return 1'b0;
        if (force1) return 1'b1;
        return ^(v & key);
    endfunction

    logic [6:0] px1;
    logic [6:0] px3 [0:2];
    always @(posedge clk) begin
        px1    <= b1.x;
        px3[0] <= b3.x;
        px3[1] <= px3[0];
        px3[2] <= px3[1];
    end
    assign b1.z0 = resp(px1);
    assign b3.z0 = resp(px3[2]);

    logic [6:0]  x_o;
    logic        xv_o, busy_o, done_o, pass_o;
    logic [15:0] sig_o;
    logic [7:0]  ones_o;
    always_comb begin
        x_o    = sel ? b3.x          : b1.x;
        xv_o   = sel ? b3.x_valid    : b1.x_valid;
        busy_o = sel ? b3.busy       : b1.busy;
        done_o = sel ? b3.done       : b1.done;
        pass_o = sel ? b3.pass       : b1.pass;
        sig_o  = sel ? b3.signature  : b1.signature;
        ones_o = sel ? b3.ones_count : b1.ones_count;
    end

    logic [6:0] seen [$];
    int valid_cyc;
    int drain_cyc;
    always @(negedge clk) begin
        if (!rst) begin
            if (xv_o) begin
                seen.push_back(x_o);
                valid_cyc++;
            end
            if (busy_o && !xv_o) drain_cyc++;
        end
    end

    // Reference model: vector list, signature, ones count for one run.
    logic [6:0]  exp_q [$];
    logic [15:0] exp_sig;
    int          exp_ones;

    function automatic void model(input logic m, input logic [7:0] nv);
        int n;
        logic [6:0] v;
        logic z;
        n = (nv != 0) ? int'(nv) : (m ? 127 : 128);
        exp_q.delete();
        exp_sig = 16'h0000;
        exp_ones = 0;
        v = 7'h01;
        for (int i = 0; i < n; i++) begin
            if (!m) v = 7'(i % 128);
            exp_q.push_back(v);
            z = resp(v);
            exp_ones += int'(z);
            exp_sig = (exp_sig << 1) ^ (exp_sig[15] ? 16'h100B : 16'h0000) ^ {15'b0, z};
            if (m) v = {v[5:0], v[6] ^ v[5]};
        end
        if (exp_ones > 255) exp_ones = 255;
    endfunction

    function automatic logic [15:0] golden();
        return sel ? 16'h000D : 16'h0003;
    endfunction

    function automatic bit seq_ok();
        if (seen.size() != exp_q.size()) return 1'b0;
        foreach (exp_q[i]) if (seen[i] !== exp_q[i]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic do_run(input logic m, input logic [7:0] nv, output int cyc, output bit to);
        @(negedge clk);
        mode = m;
        num_vec = nv;
        start = 1'b1;
        seen.delete();
        valid_cyc = 0;
        drain_cyc = 0;
        @(posedge clk);
        #1 start = 1'b0;
        cyc = 0;
        to = 1'b1;
        while (cyc < 600) begin
            @(negedge clk);
            if (done_o) begin
                to = 1'b0;
                break;
            end
            @(posedge clk);
            cyc++;
        end
    endtask

    task automatic test_reset();
        #1;
        vectors++;
        if ({b1.x, b1.x_valid, b1.busy, b1.done, b1.pass} !== 11'b0) begin
            miscompares++;
            $display("FAIL reset_ctl1 got x=%h v=%b busy=%b done=%b pass=%b want all 0",
                     b1.x, b1.x_valid, b1.busy, b1.done, b1.pass);
        end
        vectors++;
        if ({b1.signature, b1.ones_count} !== 24'h0) begin
            miscompares++;
            $display("FAIL reset_sig1 got sig=%h ones=%0d want 0/0", b1.signature, b1.ones_count);
        end
        vectors++;
        if ({b3.x_valid, b3.busy, b3.done, b3.signature, b3.ones_count} !== 27'h0) begin
            miscompares++;
            $display("FAIL reset_dut3 got v=%b busy=%b done=%b sig=%h ones=%0d want 0",
                     b3.x_valid, b3.busy, b3.done, b3.signature, b3.ones_count);
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_count_single();
        int cyc; bit to;
        sel = 1'b0; key = 7'h7F;
        model(1'b0, 8'd1);
        do_run(1'b0, 8'd1, cyc, to);
        vectors++;
        if (to || cyc != 2) begin
            miscompares++;
            $display("FAIL single_latency got %0d cycles (timeout=%b) want 2", cyc, to);
        end
        vectors++;
        if (seen.size() != 1 || seen[0] !== 7'h00) begin
            miscompares++;
            $display("FAIL single_vec got %0d vectors want 1 vector 00", seen.size());
        end
        vectors++;
        if (sig_o !== 16'h0000 || ones_o !== 8'd0 || busy_o !== 1'b0) begin
            miscompares++;
            $display("FAIL single_result got sig=%h ones=%0d busy=%b want 0000/0/0", sig_o, ones_o, busy_o);
        end
    endtask

    task automatic test_count_three();
        int cyc; bit to;
        sel = 1'b0; key = 7'h7F;
        model(1'b0, 8'd3);
        do_run(1'b0, 8'd3, cyc, to);
        vectors++;
        if (to || !seq_ok()) begin
            miscompares++;
            $display("FAIL three_seq got %0d vectors (timeout=%b) want 0,1,2", seen.size(), to);
        end
        vectors++;
        if (sig_o !== 16'h0003 || ones_o !== 8'd2 || pass_o !== 1'b1) begin
            miscompares++;
            $display("FAIL three_result got sig=%h ones=%0d pass=%b want 0003/2/1", sig_o, ones_o, pass_o);
        end
    endtask

    task automatic test_count_full();
        int cyc; bit to;
        sel = 1'b0; key = 7'h7F;
        model(1'b0, 8'd0);
        do_run(1'b0, 8'd0, cyc, to);
        vectors++;
        if (to || valid_cyc != 128 || !seq_ok()) begin
            miscompares++;
            $display("FAIL full_count_seq got %0d valid cycles (timeout=%b) want 128 vectors 0..127", valid_cyc, to);
        end
        vectors++;
        if (ones_o !== 8'd64 || sig_o !== exp_sig) begin
            miscompares++;
            $display("FAIL full_count_result got sig=%h ones=%0d want %h/64", sig_o, ones_o, exp_sig);
        end
        vectors++;
        if (pass_o !== (exp_sig == golden())) begin
            miscompares++;
            $display("FAIL full_count_pass got %b want %b", pass_o, exp_sig == golden());
        end
    endtask

    task automatic test_lfsr_full();
        int cyc; bit to; bit hit [128]; bit uniq;
        sel = 1'b0; key = 7'h7F;
        model(1'b1, 8'd0);
        do_run(1'b1, 8'd0, cyc, to);
        uniq = 1'b1;
        foreach (hit[i]) hit[i] = 1'b0;
        foreach (seen[i]) begin
            if (seen[i] == 7'h00 || hit[seen[i]]) uniq = 1'b0;
            else hit[seen[i]] = 1'b1;
        end
        vectors++;
        if (to || valid_cyc != 127 || !uniq) begin
            miscompares++;
            $display("FAIL lfsr_space got %0d valid cycles unique=%b (timeout=%b) want 127 distinct nonzero", valid_cyc, uniq, to);
        end
        vectors++;
        if (seen.size() < 2 || seen[0] !== 7'h01 || seen[1] !== 7'h02 || !seq_ok()) begin
            miscompares++;
            $display("FAIL lfsr_seq got first=%h second=%h want 01 02 and model order",
                     seen.size() > 0 ? seen[0] : 7'h7F, seen.size() > 1 ? seen[1] : 7'h7F);
        end
        vectors++;
        if (ones_o !== 8'd64 || sig_o !== exp_sig) begin
            miscompares++;
            $display("FAIL lfsr_result got sig=%h ones=%0d want %h/64", sig_o, ones_o, exp_sig);
        end
    endtask

    task automatic test_lat3();
        int cyc; bit to;
        sel = 1'b1; key = 7'h7F;
        model(1'b0, 8'd5);
        do_run(1'b0, 8'd5, cyc, to);
        vectors++;
        if (to || drain_cyc != 3 || valid_cyc != 5) begin
            miscompares++;
            $display("FAIL lat3_timing got drain=%0d valid=%0d (timeout=%b) want 3/5", drain_cyc, valid_cyc, to);
        end
        vectors++;
        if (sig_o !== 16'h000D || sig_o !== exp_sig || pass_o !== 1'b1) begin
            miscompares++;
            $display("FAIL lat3_result got sig=%h pass=%b want 000D/1", sig_o, pass_o);
        end
        force1 = 1'b1;
        model(1'b0, 8'd5);
        do_run(1'b0, 8'd5, cyc, to);
        vectors++;
        if (to || ones_o !== 8'd5 || sig_o !== exp_sig) begin
            miscompares++;
            $display("FAIL lat3_captures got ones=%0d sig=%h want 5/%h", ones_o, sig_o, exp_sig);
        end
        force1 = 1'b0;
        stuck0 = 1'b1;
        do_run(1'b0, 8'd5, cyc, to);
        vectors++;
        if (to || pass_o !== 1'b0 || sig_o !== 16'h0000 || ones_o !== 8'd0) begin
            miscompares++;
            $display("FAIL lat3_stuck got pass=%b sig=%h ones=%0d want 0/0000/0", pass_o, sig_o, ones_o);
        end
        stuck0 = 1'b0;
    endtask

    task automatic test_start_during_run();
        int cyc; bit to;
        sel = 1'b0; key = 7'($urandom_range(1, 127));
        model(1'b1, 8'd20);
        fork
            do_run(1'b1, 8'd20, cyc, to);
            begin
                repeat (6) @(negedge clk);
                start = 1'b1;
                @(negedge clk);
                start = 1'b0;
            end
        join
        vectors++;
        if (to || valid_cyc != 20 || !seq_ok()) begin
            miscompares++;
            $display("FAIL start_in_run_seq got %0d valid cycles (timeout=%b) want 20", valid_cyc, to);
        end
        vectors++;
        if (sig_o !== exp_sig || ones_o !== 8'(exp_ones)) begin
            miscompares++;
            $display("FAIL start_in_run_result got sig=%h ones=%0d want %h/%0d", sig_o, ones_o, exp_sig, exp_ones);
        end
    endtask

    task automatic test_reset_mid_run();
        int cyc; bit to;
        sel = 1'b0; key = 7'h7F;
        @(negedge clk);
        mode = 1'b0; num_vec = 8'd100; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (10) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        vectors++;
        if ({b1.x, b1.x_valid, b1.busy, b1.done, b1.pass, b1.signature, b1.ones_count} !== 35'h0) begin
            miscompares++;
            $display("FAIL midrun_reset got x=%h v=%b busy=%b done=%b pass=%b sig=%h ones=%0d want all 0",
                     b1.x, b1.x_valid, b1.busy, b1.done, b1.pass, b1.signature, b1.ones_count);
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        vectors++;
        if (b1.done !== 1'b0 || b1.busy !== 1'b0) begin
            miscompares++;
            $display("FAIL midrun_idle got done=%b busy=%b want 0/0", b1.done, b1.busy);
        end
        key = 7'($urandom_range(1, 127));
        model(1'b0, 8'd7);
        do_run(1'b0, 8'd7, cyc, to);
        vectors++;
        if (to || !seq_ok() || sig_o !== exp_sig || ones_o !== 8'(exp_ones)) begin
            miscompares++;
            $display("FAIL midrun_rerun got sig=%h ones=%0d (timeout=%b) want %h/%0d", sig_o, ones_o, to, exp_sig, exp_ones);
        end
    endtask

    task automatic test_random();
        int cyc; bit to; logic m; logic [7:0] nv;
        for (int i = 0; i < 10; i++) begin
            sel = 1'($urandom_range(0, 1));
            m   = 1'($urandom_range(0, 1));
            nv  = ($urandom_range(0, 4) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
            key = 7'($urandom);
            model(m, nv);
            do_run(m, nv, cyc, to);
            vectors++;
            if (to || !seq_ok()) begin
                miscompares++;
                $display("FAIL rand%0d_seq mode=%b nv=%0d got %0d vectors (timeout=%b) want %0d",
                         i, m, nv, seen.size(), to, exp_q.size());
            end
            vectors++;
            if (sig_o !== exp_sig || ones_o !== 8'(exp_ones) || pass_o !== (exp_sig == golden())) begin
                miscompares++;
                $display("FAIL rand%0d_result got sig=%h ones=%0d pass=%b want %h/%0d/%b",
                         i, sig_o, ones_o, pass_o, exp_sig, exp_ones, exp_sig == golden());
            end
            vectors++;
            if (drain_cyc != (sel ? 3 : 1)) begin
                miscompares++;
                $display("FAIL rand%0d_drain got %0d want %0d", i, drain_cyc, sel ? 3 : 1);
            end
        end
    endtask

    initial begin
        test_reset();
        test_count_single();
        test_count_three();
        test_count_full();
        test_lfsr_full();
        test_lat3();
        test_start_during_run();
        test_reset_mid_run();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/rd73_bist_driver.md
Name: rd73_bist_driver

Overview:
- Sequential stimulus/response stage that sits directly upstream of the rd73f2 NOR-mapped parity block.
- Generates the 7-bit input vectors x[6:0] and captures the block's z0 output `DUT_LAT` cycles later.
- Compresses the captured z0 stream into a MISR signature and counts the ones.
- Compares the final signature against a golden value, so crossbar-mapped benchmark evaluation self-checks in simulation or silicon.

Parameters:
- N_IN, 7, width of the generated vector; fixed at 7 for rd73.
- DUT_LAT, 1, cycles from a vector being driven to its z0 being valid; legal range 0..7.
- SIG_W, 16, MISR width.
- MISR_POLY, 16'h100B, feedback taps (x^16+x^12+x^3+x+1, lower terms).
- GOLDEN_SIG, 16'h0000, expected signature, overridden per run configuration.

Ports:
- clk  in  1  single clock; all state on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request to begin a run; honoured only in IDLE or DONE.
- mode  in  1  0 = binary up-counter vectors; 1 = 7-bit LFSR vectors. Sampled on start.
- num_vec  in  8  number of vectors to issue. Sampled on start. 0 means full space: 128 in counter mode, 127 in LFSR mode.
- x  out  N_IN  vector driven to the downstream block.
- x_valid  out  1  high while x holds a vector being issued.
- z0  in  1  response from the downstream block.
- busy  out  1  high in RUN and DRAIN.
- done  out  1  high in DONE; held until next start or reset.
- pass  out  1  valid while done is high: signature == GOLDEN_SIG.
- signature  out  SIG_W  current MISR contents.
- ones_count  out  8  number of captured z0 == 1.

Behaviour:
- Reset (asynchronous, immediate): state = IDLE; x = 0, x_valid = 0, busy = 0, done = 0, pass = 0, signature = 0, ones_count = 0; capture delay line cleared.
  - Reset mid-run aborts with no partial done.
- States: IDLE, RUN, DRAIN, DONE.
- IDLE/DONE + start → RUN:
  - Latch mode and effective count N (num_vec, or 128/127 when num_vec is 0).
  - Clear signature, ones_count and issued count.
  - Generator seed: counter = 0; LFSR = 7'h01.
- RUN: one vector per cycle. x = generator value, x_valid = 1, then advance the generator.
  - Counter mode: +1, wrapping 127→0.
  - LFSR mode: Fibonacci x^7+x^6+1, shift left with new bit0 = x[6]^x[5]; period 127; never zero.
  - After the Nth vector is issued: go to DRAIN if DUT_LAT > 0, else go straight to DONE.
- Capture: x_valid passes through a DUT_LAT-deep delay line.
  - When the delayed valid is 1, sample z0 and update the MISR: fb = sig[15]; sig <= (sig<<1) ^ (fb ? MISR_POLY : 0) ^ {15'b0, z0}.
  - On the same edge, ones_count += z0.
  - DUT_LAT = 0: z0 is sampled in the same cycle that x is driven.
- DRAIN: x_valid = 0 and x holds its last value. Stay DUT_LAT cycles until the last response is captured, then go to DONE.
- DONE: done = 1 and pass = (signature == GOLDEN_SIG), registered on DRAIN→DONE.
  - signature and ones_count are frozen.
- start in RUN or DRAIN is ignored.
- start in DONE restarts on the next edge; done drops in the same cycle busy rises.
- ones_count saturates at 255; this cannot occur with N ≤ 128.
- Exactly N responses are captured per run. No response is lost or duplicated at the RUN→DRAIN boundary, including when N = 1.

Decomposition:
- Package rd73_bist_pkg holds:
  - state enum {IDLE, RUN, DRAIN, DONE};
  - mode encoding constants;
  - default MISR_POLY;
  - LFSR tap constant and seed;
  - full-space counts 128/127.
- One natural sub-module: rd73_misr. Inputs are clk, rst, clr, en, din; output is sig. It is parameterised by SIG_W and MISR_POLY.
- The generator and FSM stay in the top module.

Test Plan:
- Counter mode, num_vec = 1, DUT_LAT = 1, parity model attached → x = 0 issued for one cycle; z0 = 0; signature = 16'h0000, ones_count = 0. done rises 2 cycles after start was sampled.
- Counter mode, num_vec = 3 → x sequence 0, 1, 2; z0 sequence 0, 1, 1; signature = 16'h0003, ones_count = 2, pass = 1 with GOLDEN_SIG = 16'h0003.
- Counter mode, num_vec = 0 → 128 vectors 0..127, x_valid high for exactly 128 cycles; ones_count = 64. The resulting signature becomes GOLDEN_SIG, and a rerun gives pass = 1.
- LFSR mode, num_vec = 0 → 127 distinct nonzero vectors starting at 7'h01, second vector 7'h02, no repeat; ones_count = 64.
- DUT_LAT = 3 sweep with num_vec = 5 → DRAIN lasts 3 cycles and exactly 5 captures occur. Inject a stuck-at-0 z0 → pass = 0.
- Robustness:
  - Assert rst mid-RUN → all outputs return to reset values immediately.
  - A subsequent start runs cleanly.
  - start pulsed during RUN has no effect on count or signature.
